alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_types.sv | 24 ++
 rtl/alu.sv | 49 ++++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_types.sv
// Shared types for the ALU and the two-requester ALU arbiter.
// alu_control_t encodes the ALU operation; bit 2 selects subtract/compare.
package alu_types;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_NOR = 4'b1100
    } alu_control_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } alu_arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: control[2] inverts b and injects carry for SUB/SLT,
// shifts use b[4:0], unused encodings give result 0 (and therefore zero=1).
module alu
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_control_t control_i,
    output logic [N-1:0] result_o,
    output logic         overflow_o,
    output logic         zero_o,
    output logic         equal_o
);

    logic [N-1:0] b_eff;
    logic [N-1:0] sum;
    logic         ovf_raw;
    logic         is_arith;

    always_comb begin
        b_eff    = control_i[2] ? ~b_i : b_i;
        sum      = a_i + b_eff + {{(N-1){1'b0}}, control_i[2]};
        ovf_raw  = (a_i[N-1] == b_eff[N-1]) && (sum[N-1] != a_i[N-1]);
        is_arith = 1'b0;
        result_o = '0;
        case (control_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_XOR: result_o = a_i ^ b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_ADD, ALU_SUB: begin
                result_o = sum;
                is_arith = 1'b1;
            end
            // signed less-than: sign of a-b corrected by its overflow
            ALU_SLT: result_o = {{(N-1){1'b0}}, sum[N-1] ^ ovf_raw};
            ALU_SLL: result_o = a_i << b_i[4:0];
            ALU_SRL: result_o = a_i >> b_i[4:0];
            ALU_SRA: result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            default: result_o = '0;
        endcase
        overflow_o = is_arith & ovf_raw;
        zero_o     = (result_o == '0);
        equal_o    = (a_i == b_i);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARBITER_FLAGS_EN to register and output the ALU flags.
module alu_arbiter
    import alu_types::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  alu_control_t req0_control,
    input  alu_control_t req1_control,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_overflow,
    output logic         rsp_zero,
    output logic         rsp_equal
);

    alu_arb_state_t state_q;
    logic           last_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    alu_control_t   ctrl_q;
    logic           id_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [N-1:0]   result_q;
    logic           grant0;
    logic           grant1;
    logic [N-1:0]   alu_result;
    logic           alu_ovf;
    logic           alu_zero;
    logic           alu_eq;

    // last_q==1 means requester 1 was granted last, so requester 0 wins a tie
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_q);
        grant1     = req1_valid && !grant0;
        req0_ready = rst_n && (state_q == IDLE) && grant0;
        req1_ready = rst_n && (state_q == IDLE) && grant1;
    end

    alu #(.N(N)) u_alu (
        .a_i       (a_q),
        .b_i       (b_q),
        .control_i (ctrl_q),
        .result_o  (alu_result),
        .overflow_o(alu_ovf),
        .zero_o    (alu_zero),
        .equal_o   (alu_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= ALU_AND;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q     <= grant1 ? req1_a : req0_a;
                        b_q     <= grant1 ? req1_b : req0_b;
                        ctrl_q  <= grant1 ? req1_control : req0_control;
                        id_q    <= grant1;
                        last_q  <= grant1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    result_q    <= alu_result;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = result_q;

`ifdef ALU_ARBITER_FLAGS_EN
    logic ovf_q;
    logic zero_q;
    logic eq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            eq_q   <= 1'b0;
        end else if (state_q == EXEC) begin
            ovf_q  <= alu_ovf;
            zero_q <= alu_zero;
            eq_q   <= alu_eq;
        end
    end

    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign rsp_equal    = eq_q;
`else
    logic flags_unused;
    assign flags_unused = alu_ovf ^ alu_zero ^ alu_eq;
    assign rsp_overflow = 1'b0;
    assign rsp_zero     = 1'b0;
    assign rsp_equal    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus a response scoreboard,
// with hand-written tie, backpressure and mid-operation reset sequences.
module tb_alu_arbiter;
    import alu_types::*;

    localparam int unsigned N = 32;
`ifdef ALU_ARBITER_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    alu_control_t req0_control, req1_control;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_overflow, rsp_zero, rsp_equal;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req0_control(req0_control),
        .req1_control(req1_control),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_overflow(rsp_overflow),
        .rsp_zero    (rsp_zero),
        .rsp_equal   (rsp_equal)
    );

    typedef struct {
        logic         id;
        logic [N-1:0] res;
        logic         z;
        logic         ov;
        logic         eq;
    } exp_t;

    typedef struct {
        logic         sel;
        alu_control_t ctrl;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         z;
        logic         ov;
        logic         eq;
    } vec_t;

    exp_t        sb[$];
    int unsigned nvec = 0;
    int unsigned nerr = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [N-1:0] res, input logic z, input logic ov,
                        input logic eq);
        exp_t e;
        e.id = id; e.res = res; e.z = z & FL; e.ov = ov & FL; e.eq = eq & FL;
        sb.push_back(e);
    endtask

    task automatic drive(input logic sel, input alu_control_t c, input logic [N-1:0] a,
                         input logic [N-1:0] b);
        if (sel) begin
            req1_valid = 1'b1; req1_control = c; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_control = c; req0_a = a; req0_b = b;
        end
    endtask

    task automatic scramble();
        req0_a = $urandom(); req0_b = $urandom();
        req1_a = $urandom(); req1_b = $urandom();
        req0_control = ALU_SUB; req1_control = ALU_OR;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain_left", N'(sb.size()), '0);
        tick();
    endtask

    // response monitor and per-cycle ready invariants
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            chk1("ready_onehot", req0_ready & req1_ready, 1'b0);
            if (rsp_valid) chk1("ready_in_resp", req0_ready | req1_ready, 1'b0);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_rsp: got id %0b result %0h, want no response",
                             rsp_id, rsp_result);
                end else begin
                    e = sb.pop_front();
                    chk1("rsp_id", rsp_id, e.id);
                    chk("rsp_result", rsp_result, e.res);
                    chk1("rsp_zero", rsp_zero, e.z);
                    chk1("rsp_overflow", rsp_overflow, e.ov);
                    chk1("rsp_equal", rsp_equal, e.eq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{1'b0, ALU_ADD, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, ALU_SUB, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, ALU_AND, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, ALU_OR,  32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, ALU_SLL, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, ALU_SRL, 32'h80000000, 32'h23,       32'h10000000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, ALU_SRA, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, ALU_SLT, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, ALU_ADD, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, alu_control_t'(4'hF), 32'd3, 32'd3,  32'd0,        1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, ALU_NOR, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, ALU_SUB, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b1};

        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_control = ALU_AND; req1_control = ALU_AND;

        // asynchronous reset before any clock edge; ready gated even with a valid request
        #1 rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk1("rst_req1_ready", req1_ready, 1'b0);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_result", rsp_result, '0);
        chk1("rst_flags", rsp_overflow | rsp_zero | rsp_equal, 1'b0);
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // tie from reset: grants alternate 0, 1, 0
        drive(1'b0, ALU_SUB, 32'd3, 32'd3);
        drive(1'b1, ALU_XOR, 32'hF0, 32'h0F);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk1("tie_req0_ready", req0_ready, (g % 2) == 0);
            chk1("tie_req1_ready", req1_ready, (g % 2) == 1);
            if ((g % 2) == 0) push(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
            else              push(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
            if (g < 2) begin
                repeat (2) begin
                    @(negedge clk);
                    chk1("tie_busy_ready", req0_ready | req1_ready, 1'b0);
                end
            end
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        // single-requester vectors; operands scrambled right after acceptance
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].sel, vecs[i].ctrl, vecs[i].a, vecs[i].b);
            @(negedge clk);
            chk1("vec_ready_sel", vecs[i].sel ? req1_ready : req0_ready, 1'b1);
            chk1("vec_ready_other", vecs[i].sel ? req0_ready : req1_ready, 1'b0);
            push(vecs[i].sel, vecs[i].res, vecs[i].z, vecs[i].ov, vecs[i].eq);
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            scramble();
            @(negedge clk);
            chk1("lat_exec_valid", rsp_valid, 1'b0);
            tick();
            @(negedge clk);
            chk1("lat_resp_valid", rsp_valid, 1'b1);
            tick();
        end

        // backpressure: five cycles in RESP with both requesters active
        rsp_ready = 1'b0;
        drive(1'b0, ALU_ADD, 32'h10, 32'h20);
        @(negedge clk);
        chk1("bp_accept", req0_ready, 1'b1);
        push(1'b0, 32'h30, 1'b0, 1'b0, 1'b0);
        tick();
        req0_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            scramble();
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            @(negedge clk);
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_result", rsp_result, 32'h30);
            chk1("bp_rsp_id", rsp_id, 1'b0);
            chk1("bp_ready", req0_ready | req1_ready, 1'b0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk1("bp_release_idle", rsp_valid, 1'b0);
        tick();

        // reset mid-EXEC after a requester-0 grant: outputs clear, no stale response,
        // and requester 0 wins the next tie
        drive(1'b0, ALU_ADD, 32'd1, 32'd1);
        @(negedge clk);
        chk1("rst_test_accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk1("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_rsp_result", rsp_result, '0);
        chk1("midrst_rsp_id", rsp_id, 1'b0);
        chk1("midrst_flags", rsp_overflow | rsp_zero | rsp_equal, 1'b0);
        drive(1'b0, ALU_ADD, 32'd2, 32'd2);
        drive(1'b1, ALU_OR, 32'd1, 32'd2);
        #1;
        chk1("midrst_ready", req0_ready | req1_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk1("postrst_no_stale", rsp_valid, 1'b0);
        chk1("postrst_tie_req0", req0_ready, 1'b1);
        chk1("postrst_tie_req1", req1_ready, 1'b0);
        push(1'b0, 32'd4, 1'b0, 1'b0, 1'b1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
